// File: rtl/spi_fsm_pkg.sv
// Shared definitions for the SPI memory-slave transaction controller:
// state encoding and default byte/settle sizes.
`timescale 1ns/1ps
package spi_fsm_pkg;

   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_SETTLE_CYCLES = 2;

   typedef enum logic [3:0] {
      IDLE         = 4'd0,
      GET_ADDR     = 4'd1,
      ADDR_SETTLE  = 4'd2,
      LATCH_ADDR   = 4'd3,
      READ_WAIT    = 4'd4,
      READ_LOAD    = 4'd5,
      READ_SHIFT   = 4'd6,
      WRITE_GET    = 4'd7,
      WRITE_SETTLE = 4'd8,
      WRITE_MEM    = 4'd9,
      DONE         = 4'd10
   } stateT;

endpackage

// File: rtl/spi_fsm_edge_counter.sv
// Bit counter for one byte phase: synchronous clear, count enable, and a
// terminal flag that is high while the next counted strobe is the last one.
`timescale 1ns/1ps
module edge_counter #(
   parameter int data_width = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic countEn,
   output logic termCount
);

   localparam int CW = $clog2(data_width) + 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (countEn) begin
         count <= count + 1'b1;
      end
   end

   assign termCount = (count == CW'(data_width - 1));

endmodule

// File: rtl/spi_fsm.sv
// SPI memory-slave transaction controller: address/R-W byte, then either a
// read (load + shift out on MISO) or a write (collect byte + memory write).
`timescale 1ns/1ps
module spi_fsm
   import spi_fsm_pkg::*;
#(
   parameter int data_width    = DEF_DATA_WIDTH,
   parameter int settle_cycles = DEF_SETTLE_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs_n,
   input  logic       sclk_posedge,
   input  logic       sclk_negedge,
   input  logic       rw_bit,
   output logic       sr_parallel_load,
   output logic       addr_we,
   output logic       dm_we,
   output logic       miso_buff_en,
   output logic [3:0] state
);

   localparam int SW = $clog2(settle_cycles + 1);

   stateT         curState;
   stateT         nextState;
   logic          bitClear;
   logic          bitCountEn;
   logic          bitTerm;
   logic [SW-1:0] settleCnt;
   logic          settleDone;
   logic          nextLoad;
   logic          nextAddrWe;
   logic          nextDmWe;
   logic          nextMisoEn;

   edge_counter #(
      .data_width(data_width)
   ) bitCounter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bitClear),
      .countEn  (bitCountEn),
      .termCount(bitTerm)
   );

   // Outputs are registered from the next state so they line up with curState.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curState         <= IDLE;
         sr_parallel_load <= 1'b0;
         addr_we          <= 1'b0;
         dm_we            <= 1'b0;
         miso_buff_en     <= 1'b0;
      end else begin
         curState         <= nextState;
         sr_parallel_load <= nextLoad;
         addr_we          <= nextAddrWe;
         dm_we            <= nextDmWe;
         miso_buff_en     <= nextMisoEn;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settleCnt <= '0;
      end else if (nextState != curState) begin
         settleCnt <= '0;
      end else if (curState == ADDR_SETTLE || curState == WRITE_SETTLE) begin
         settleCnt <= settleCnt + 1'b1;
      end
   end

   assign settleDone = (settleCnt == SW'(settle_cycles - 1));

   // Chip-select release outranks every other transition, even a final strobe.
   always_comb begin
      nextState  = curState;
      bitCountEn = 1'b0;
      if (curState != IDLE && cs_n) begin
         nextState = IDLE;
      end else begin
         case (curState)
            IDLE:         if (!cs_n) nextState = GET_ADDR;
            GET_ADDR: begin
               if (sclk_posedge) begin
                  bitCountEn = 1'b1;
                  if (bitTerm) nextState = ADDR_SETTLE;
               end
            end
            ADDR_SETTLE:  if (settleDone) nextState = LATCH_ADDR;
            LATCH_ADDR:   nextState = rw_bit ? READ_WAIT : WRITE_GET;
            READ_WAIT:    nextState = READ_LOAD;
            READ_LOAD:    nextState = READ_SHIFT;
            READ_SHIFT: begin
               if (sclk_negedge) begin
                  bitCountEn = 1'b1;
                  if (bitTerm) nextState = DONE;
               end
            end
            WRITE_GET: begin
               if (sclk_posedge) begin
                  bitCountEn = 1'b1;
                  if (bitTerm) nextState = WRITE_SETTLE;
               end
            end
            WRITE_SETTLE: if (settleDone) nextState = WRITE_MEM;
            WRITE_MEM:    nextState = DONE;
            DONE:         nextState = DONE;
            default:      nextState = IDLE;
         endcase
      end
   end

   // Any state change restarts the bit count, which covers entry to each
   // counting state as well as chip-select release.
   assign bitClear = (nextState != curState);

   always_comb begin
      nextLoad   = 1'b0;
      nextAddrWe = 1'b0;
      nextDmWe   = 1'b0;
      nextMisoEn = 1'b0;
      case (nextState)
         READ_LOAD:  nextLoad   = 1'b1;
         LATCH_ADDR: nextAddrWe = 1'b1;
         WRITE_MEM:  nextDmWe   = 1'b1;
         READ_SHIFT: nextMisoEn = 1'b1;
         default:    ;
      endcase
   end

   assign state = curState;

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm: per-cycle trace comparison against a
// timeline model built from strobe positions in each transaction.
`timescale 1ns/1ps
module tb_spi_fsm;
  import spi_fsm_pkg::*;

  localparam int DW  = DEF_DATA_WIDTH;
  localparam int SC  = DEF_SETTLE_CYCLES;
  localparam int N   = 120;
  localparam int INF = 1 << 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sclk_posedge = 1'b0;
  logic       sclk_negedge = 1'b0;
  logic       rw_bit = 1'b0;
  logic       sr_parallel_load;
  logic       addr_we;
  logic       dm_we;
  logic       miso_buff_en;
  logic [3:0] state;
  logic [7:0] obs;

  spi_fsm dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cs_n            (cs_n),
    .sclk_posedge    (sclk_posedge),
    .sclk_negedge    (sclk_negedge),
    .rw_bit          (rw_bit),
    .sr_parallel_load(sr_parallel_load),
    .addr_we         (addr_we),
    .dm_we           (dm_we),
    .miso_buff_en    (miso_buff_en),
    .state           (state)
  );

  assign obs = {state, sr_parallel_load, addr_we, dm_we, miso_buff_en};

  // clock / reset
  always #5 clk = ~clk;

  bit cs_a[N];
  bit pos_a[N];
  bit neg_a[N];
  bit rw_a[N];

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (state,load,addr_we,dm_we,miso) at %0t", tag, got, want, $time);
    end
  endtask

  // reference model
  function automatic int nth_strobe(input bit arr[N], input int from, input int lim);
    int cnt = 0;
    for (int i = from; i < N && i < lim; i++) begin
      if (arr[i]) begin
        cnt++;
        if (cnt == DW) return i;
      end
    end
    return INF;
  endfunction

  function automatic logic [7:0] pack_exp(input int st);
    logic [3:0] s;
    s = st[3:0];
    return {s, st == 5, st == 3, st == 9, st == 6};
  endfunction

  // Cycle t entry = expected outputs just after the t-th sampling edge.
  task automatic build_expected();
    int c0, e, a8, lt, r8, w8, st;
    bit rd;
    c0 = INF;
    for (int i = 0; i < N; i++) if (!cs_a[i]) begin c0 = i; break; end
    e = INF;
    for (int i = c0 + 1; i < N; i++) if (cs_a[i]) begin e = i; break; end
    a8 = nth_strobe(pos_a, c0 + 1, e);
    lt = a8 + SC;
    rd = (lt + 1 < N) ? rw_a[lt + 1] : 1'b0;
    r8 = nth_strobe(neg_a, lt + 4, e);
    w8 = nth_strobe(pos_a, lt + 2, e);
    exp_q.delete();
    for (int t = 0; t < N; t++) begin
      if (t < c0 || t >= e)      st = 0;
      else if (t < a8)           st = 1;
      else if (t < lt)           st = 2;
      else if (t == lt)          st = 3;
      else if (rd) begin
        if (t == lt + 1)         st = 4;
        else if (t == lt + 2)    st = 5;
        else if (t < r8)         st = 6;
        else                     st = 10;
      end else begin
        if (t < w8)              st = 7;
        else if (t < w8 + SC)    st = 8;
        else if (t == w8 + SC)   st = 9;
        else                     st = 10;
      end
      exp_q.push_back(pack_exp(st));
    end
  endtask

  // drivers
  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      cs_a[i] = 1'b1; pos_a[i] = 1'b0; neg_a[i] = 1'b0; rw_a[i] = 1'b0;
    end
  endtask

  task automatic directed(input int e, input bit rw, input bit pos_all, input bit neg_early);
    clear_stim();
    for (int i = 2; i < e; i++) cs_a[i] = 1'b0;
    for (int i = 3; i < 70; i += 2) if (pos_all || i <= 17) pos_a[i] = 1'b1;
    for (int i = 4; i < 70; i += 2) if (neg_early || i >= 24) neg_a[i] = rw | neg_early;
    for (int i = 0; i < N; i++) rw_a[i] = rw;
  endtask

  task automatic gen_random(input bit abort_mode);
    int c0, e, dp, dn;
    bit rw;
    c0 = int'($urandom_range(1, 4));
    dp = int'($urandom_range(1, 4));
    dn = int'($urandom_range(1, 4));
    rw = 1'($urandom_range(0, 1));
    e  = abort_mode ? int'($urandom_range(c0 + 1, N - 4)) : N - 4;
    for (int i = 0; i < N; i++) begin
      cs_a[i]  = !(i >= c0 && i < e);
      pos_a[i] = ($urandom_range(1, dp) == 1);
      neg_a[i] = ($urandom_range(1, dn) == 1);
      rw_a[i]  = rw;
    end
  endtask

  task automatic run_trace(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cs_n = cs_a[i]; sclk_posedge = pos_a[i]; sclk_negedge = neg_a[i]; rw_bit = rw_a[i];
      @(posedge clk);
      #1;
      check(tag, obs, exp_q.pop_front());
    end
    @(negedge clk);
    sclk_posedge = 1'b0; sclk_negedge = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", obs, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    directed(100, 1'b0, 1'b1, 1'b0); build_expected(); run_trace("write", N);
    directed(100, 1'b1, 1'b0, 1'b0); build_expected(); run_trace("read", N);
    directed(28, 1'b0, 1'b1, 1'b0);  build_expected(); run_trace("abort_write", N);
    directed(100, 1'b0, 1'b1, 1'b0); build_expected(); run_trace("write_after_abort", N);
    directed(17, 1'b0, 1'b1, 1'b0);  build_expected(); run_trace("abort_on_last_addr_strobe", N);
    directed(100, 1'b1, 1'b1, 1'b1); build_expected(); run_trace("strobe_filter", N);

    // async reset in the middle of READ_SHIFT, between clock edges
    directed(100, 1'b1, 1'b0, 1'b0); build_expected(); run_trace("read_pre_reset", 29);
    #2;
    rst_n = 1'b0;
    #0.5;
    check("async_reset_outputs", obs, 8'h00);
    check("async_reset_miso", {7'h00, miso_buff_en}, 8'h00);
    #0.5;
    rst_n = 1'b1;
    clear_stim(); build_expected(); run_trace("idle_after_reset", 8);

    for (int k = 0; k < 30; k++) begin
      gen_random(($urandom_range(0, 2) == 0));
      build_expected();
      run_trace("random", N);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
